pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It drives the write-enable and flush inputs of the PC and the four pipeline buffers. It inserts load-use bubbles, flushes wrong-path instructions on a taken branch, and freezes the whole pipeline for a configurable data-memory latency. It also generates EX-stage forwarding selects and keeps saturating stall and flush statistics.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/forward_unit.sv | 21 ++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
//   state_e   : controller FSM states (RUN, WAIT)
//   FWD_*     : ALU operand forwarding select codes
//   REG_W     : register-index width
//   wb_src_t  : a writer stage as seen by the forwarding logic
//   fwd_sel() : forwarding priority for one ALU source operand
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic             regwrite;
    logic [REG_W-1:0] rd;
  } wb_src_t;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  // $0 is never forwarded because it is hardwired to zero.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input wb_src_t mem, input wb_src_t wb);
    if (mem.regwrite && mem.rd != '0 && mem.rd == src) return FWD_MEM;
    if (wb.regwrite  && wb.rd  != '0 && wb.rd  == src) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage forwarding selects, one lane per ALU source operand.
//   src   : source register indices of the EX instruction (lane 0 = rs, 1 = rt)
//   exmem : RegWrite / rd of the instruction in MEM
//   memwb : RegWrite / rd of the instruction in WB
//   fwd   : per-lane operand select (FWD_RF / FWD_MEM / FWD_WB)
module forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0][REG_W-1:0] src,
  input  wb_src_t                       exmem,
  input  wb_src_t                       memwb,
  output logic [NUM_SRC-1:0][1:0]       fwd
);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign fwd[g] = fwd_sel(src[g], exmem, memwb);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a five-stage MIPS pipeline.
// Drives PC / IF-ID / ID-EX / EX-MEM / MEM-WB load enables and bubble
// flushes, handles load-use stalls, taken-branch flushes and a data-memory
// freeze of MEM_WAIT cycles, produces EX forwarding selects and keeps
// saturating stall / flush statistics.
//   clk, rst                    : clock, async active-high reset
//   ifid_rs/rt                  : sources of the ID instruction
//   idex_rs/rt, idex_memread,
//   idex_rt_dst                 : EX instruction sources and load info
//   exmem_/memwb_regwrite, _rd  : writers in MEM / WB
//   exmem_memaccess             : MEM instruction touches data memory
//   branch_taken                : resolved taken branch
//   *_we, *_flush               : stage register enables / bubble inserts
//   fwd_a, fwd_b                : ALU operand selects
//   stall_count, flush_count    : saturating statistics
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt_dst,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             exmem_memaccess,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCNT_W = ($clog2(MEM_WAIT + 1) < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam bit HAS_WAIT = (MEM_WAIT > 0);

  state_e            state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic              frozen, load_use, stall_inc, flush_inc;
  logic [1:0][1:0]   fwd;

  // In WAIT with wcnt==0 the pipeline is released for one cycle; a memory
  // access still sitting in MEM during that cycle is the one retiring, so
  // only RUN may start a new freeze.
  assign frozen   = (state == RUN) ? (exmem_memaccess && HAS_WAIT) : (wcnt != '0);
  assign load_use = idex_memread && idex_rt_dst != '0 &&
                    (idex_rt_dst == ifid_rs || idex_rt_dst == ifid_rt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // Next state
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      RUN: if (frozen) begin
        state_n = WAIT;
        wcnt_n  = WCNT_INIT;
      end
      WAIT: if (wcnt != '0) wcnt_n = wcnt - 1'b1;
            else            state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Outputs: priority reset > freeze > branch > load-use > run
  always_comb begin
    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
    {ifid_flush, idex_flush, exmem_flush}         = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      // everything held low
    end else if (frozen) begin
      stall_inc = 1'b1;
    end else if (branch_taken) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
      {ifid_flush, idex_flush, exmem_flush}         = '1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      {idex_we, exmem_we, memwb_we} = '1;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end else begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush_inc && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

  forward_unit #(.NUM_SRC(2)) u_fwd (
    .src   ({idex_rt, idex_rs}),
    .exmem ('{regwrite: exmem_regwrite, rd: exmem_rd}),
    .memwb ('{regwrite: memwb_regwrite, rd: memwb_rd}),
    .fwd   (fwd)
  );

  assign fwd_a = rst ? FWD_RF : fwd[0];
  assign fwd_b = rst ? FWD_RF : fwd[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (MEM_WAIT=0 and MEM_WAIT=3) share
// one stimulus stream. A cycle-level model of the hazard rules is checked
// on every falling edge; directed literal checks pin key cycles.
module tb_pipeline_ctrl;

  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
  int MW[2] = '{0, 3};

  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rt_dst, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_regwrite, memwb_regwrite, exmem_memaccess, branch_taken;

  logic [1:0] pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic [1:0] ifid_flush, idex_flush, exmem_flush;
  logic [1:0][1:0]       fwd_a, fwd_b;
  logic [1:0][CNT_W-1:0] stall_count, flush_count;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int m_acc[2];
  int m_st[2], m_fl[2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    pipeline_ctrl #(.MEM_WAIT(i * 3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt),
      .idex_memread(idex_memread), .idex_rt_dst(idex_rt_dst),
      .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_memaccess(exmem_memaccess), .branch_taken(branch_taken),
      .pc_we(pc_we[i]), .ifid_we(ifid_we[i]), .idex_we(idex_we[i]),
      .exmem_we(exmem_we[i]), .memwb_we(memwb_we[i]),
      .ifid_flush(ifid_flush[i]), .idex_flush(idex_flush[i]), .exmem_flush(exmem_flush[i]),
      .fwd_a(fwd_a[i]), .fwd_b(fwd_b[i]),
      .stall_count(stall_count[i]), .flush_count(flush_count[i])
    );
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h, want %h", nm, i, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] we;   // pc, ifid, idex, exmem, memwb
    logic [2:0] fl;   // ifid, idex, exmem
    logic [1:0] fa, fb;
    bit         stall, flush;
    int         acc;
  } exp_t;

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // acc = cycle in which the current memory access was detected.
  // Cycles acc .. acc+mw-1 are frozen, acc+mw is the release cycle.
  function automatic exp_t model(input int mw, input int acc, input int c);
    exp_t e;
    bit frz, lu;
    e.acc = acc; e.stall = 0; e.flush = 0;
    e.fa = fsel(idex_rs); e.fb = fsel(idex_rt);
    if (c < acc + mw)                         frz = 1;
    else if (c == acc + mw)                   frz = 0;
    else if (exmem_memaccess && mw > 0) begin frz = 1; e.acc = c; end
    else                                      frz = 0;
    lu = idex_memread && idex_rt_dst != 0 && (idex_rt_dst == ifid_rs || idex_rt_dst == ifid_rt);
    if (frz)               begin e.we = 5'b00000; e.fl = 3'b000; e.stall = 1; end
    else if (branch_taken) begin e.we = 5'b11111; e.fl = 3'b111; e.flush = 1; end
    else if (lu)           begin e.we = 5'b00111; e.fl = 3'b010; e.stall = 1; end
    else                   begin e.we = 5'b11111; e.fl = 3'b000; end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [11:0] act;
      exp_t e;
      act = {pc_we[i], ifid_we[i], idex_we[i], exmem_we[i], memwb_we[i],
             ifid_flush[i], idex_flush[i], exmem_flush[i], fwd_a[i], fwd_b[i]};
      if (rst) begin
        chk("ctl_rst", i, 32'(act), 32'd0);
        chk("stall_rst", i, 32'(stall_count[i]), 32'd0);
        chk("flush_rst", i, 32'(flush_count[i]), 32'd0);
        m_acc[i] = -1000; m_st[i] = 0; m_fl[i] = 0;
      end else begin
        chk("stall_cnt", i, 32'(stall_count[i]), 32'(m_st[i]));
        chk("flush_cnt", i, 32'(flush_count[i]), 32'(m_fl[i]));
        e = model(MW[i], m_acc[i], cyc);
        chk("ctl", i, 32'(act), 32'({e.we, e.fl, e.fa, e.fb}));
        m_acc[i] = e.acc;
        if (e.stall && m_st[i] < CMAX) m_st[i]++;
        if (e.flush && m_fl[i] < CMAX) m_fl[i]++;
      end
    end
    cyc++;
  end

  task automatic clr();
    {ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rt_dst, exmem_rd, memwb_rd} = '0;
    {idex_memread, exmem_regwrite, memwb_regwrite, exmem_memaccess, branch_taken} = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_pc_we", 0, 32'(pc_we[0]), 32'd0);
    chk("lit_rst_stall", 0, 32'(stall_count[0]), 32'd0);
    nxt(); rst = 1'b0;

    // load-use: lw $2 in EX, ID reads $2
    idex_memread = 1; idex_rt_dst = 2; ifid_rs = 2;
    @(negedge clk);
    chk("lit_lu_pc_we", 0, 32'(pc_we[0]), 32'd0);
    chk("lit_lu_ifid_we", 0, 32'(ifid_we[0]), 32'd0);
    chk("lit_lu_idex_flush", 0, 32'(idex_flush[0]), 32'd1);
    chk("lit_lu_idex_we", 0, 32'(idex_we[0]), 32'd1);
    nxt(); idex_memread = 0;
    @(negedge clk);
    chk("lit_lu_stall_cnt", 0, 32'(stall_count[0]), 32'd1);
    chk("lit_lu_pc_we_after", 0, 32'(pc_we[0]), 32'd1);

    // branch together with load-use match
    nxt(); clr(); branch_taken = 1; idex_memread = 1; idex_rt_dst = 2; ifid_rt = 2;
    @(negedge clk);
    chk("lit_br_flushes", 0, 32'({ifid_flush[0], idex_flush[0], exmem_flush[0]}), 32'b111);
    chk("lit_br_we", 0, 32'({pc_we[0], ifid_we[0], idex_we[0], exmem_we[0], memwb_we[0]}), 32'b11111);
    nxt(); clr();
    @(negedge clk);
    chk("lit_br_flush_cnt", 0, 32'(flush_count[0]), 32'd1);
    chk("lit_br_stall_cnt", 0, 32'(stall_count[0]), 32'd1);

    // forwarding
    nxt(); exmem_regwrite = 1; exmem_rd = 5; memwb_regwrite = 1; memwb_rd = 5;
    idex_rs = 5; idex_rt = 7;
    @(negedge clk);
    chk("lit_fwd_a_mem", 0, 32'(fwd_a[0]), 32'b10);
    chk("lit_fwd_b_rf", 0, 32'(fwd_b[0]), 32'b00);
    nxt(); exmem_rd = 0; memwb_rd = 0;
    @(negedge clk);
    chk("lit_fwd_a_r0", 0, 32'(fwd_a[0]), 32'b00);
    nxt(); memwb_rd = 7;
    @(negedge clk);
    chk("lit_fwd_b_wb", 0, 32'(fwd_b[0]), 32'b01);
    chk("lit_fwd_a_rf", 0, 32'(fwd_a[0]), 32'b00);

    // memory freeze (MEM_WAIT=3 instance), branch arriving mid-freeze
    nxt(); clr(); exmem_memaccess = 1;
    @(negedge clk);
    chk("lit_frz0_pc_we", 1, 32'(pc_we[1]), 32'd0);
    chk("lit_frz0_memwb_we", 1, 32'(memwb_we[1]), 32'd0);
    chk("lit_frz0_nowait_pc_we", 0, 32'(pc_we[0]), 32'd1);
    nxt(); branch_taken = 1;
    @(negedge clk);
    chk("lit_frz1_pc_we", 1, 32'(pc_we[1]), 32'd0);
    chk("lit_frz1_ifid_flush", 1, 32'(ifid_flush[1]), 32'd0);
    nxt();
    @(negedge clk);
    chk("lit_frz2_pc_we", 1, 32'(pc_we[1]), 32'd0);
    nxt();
    @(negedge clk);
    chk("lit_rel_pc_we", 1, 32'(pc_we[1]), 32'd1);
    chk("lit_rel_memwb_we", 1, 32'(memwb_we[1]), 32'd1);
    chk("lit_rel_ifid_flush", 1, 32'(ifid_flush[1]), 32'd1);
    nxt(); clr();
    @(negedge clk);
    chk("lit_frz_stall_cnt", 1, 32'(stall_count[1]), 32'd4);
    chk("lit_frz_flush_cnt", 1, 32'(flush_count[1]), 32'd2);
    chk("lit_nowait_flush_cnt", 0, 32'(flush_count[0]), 32'd4);

    // reset asserted while in WAIT
    nxt(); exmem_memaccess = 1;
    @(negedge clk);
    chk("lit_rw_frz", 1, 32'(pc_we[1]), 32'd0);
    nxt(); exmem_memaccess = 0; rst = 1;
    @(negedge clk);
    chk("lit_rw_stall_async", 1, 32'(stall_count[1]), 32'd0);
    chk("lit_rw_we_low", 1, 32'(memwb_we[1]), 32'd0);
    nxt(); rst = 0;
    @(negedge clk);
    chk("lit_rw_no_residual", 1, 32'(pc_we[1]), 32'd1);
    nxt();
    @(negedge clk);
    chk("lit_rw_no_residual2", 1, 32'(pc_we[1]), 32'd1);

    // saturation: 2^16+5 load-use stalls
    nxt(); idex_memread = 1; idex_rt_dst = 2; ifid_rs = 2;
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    #1 clr();
    @(negedge clk);
    chk("lit_sat_stall", 0, 32'(stall_count[0]), 32'hFFFF);
    chk("lit_sat_stall", 1, 32'(stall_count[1]), 32'hFFFF);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
